// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: shared state encoding and sizing helper for the PLL reset sequencer
package pll_rst_pkg;
   typedef enum logic [1:0] {S_WAIT, S_STABLE, S_RELEASE, S_RUN} seq_state_t;
   function automatic int max_cycles(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: multi-flop synchroniser for the asynchronous PLL lock flag
module pll_lock_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [SYNC_STAGES-1:0] ff;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ff <= '0;
      else ff <= {ff[SYNC_STAGES-2:0], d};
   assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: waits for stable PLL lock, then releases stage resets in order.
// Define LOCK_LOSS_CNT_EN to add the saturating lock_loss_cnt_o counter.
module pll_reset_sequencer
   import pll_rst_pkg::*;
#(
   parameter int NUM_STAGES   = 4,
   parameter int LOCK_CYCLES  = 1024,
   parameter int STAGE_CYCLES = 16,
   parameter int SYNC_STAGES  = 2,
   parameter int CNT_W        = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  pll_locked_i,
   output logic [NUM_STAGES-1:0] rst_no,
   output logic                  ready_o
`ifdef LOCK_LOSS_CNT_EN
   ,
   output logic [CNT_W-1:0]      lock_loss_cnt_o
`endif
);
   localparam int TW = $clog2(max_cycles(LOCK_CYCLES, STAGE_CYCLES) + 1);
   localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   if (NUM_STAGES < 1 || LOCK_CYCLES < 1 || STAGE_CYCLES < 1 || SYNC_STAGES < 2 || CNT_W < 1) begin : g_bad_params
      $error("pll_reset_sequencer: invalid parameters");
   end
   seq_state_t    state;
   logic [TW-1:0] timer;
   logic [IW-1:0] idx;
   logic          lock_s;
   pll_lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .d     (pll_locked_i),
      .q     (lock_s)
   );
   // A low synced lock overrides everything, including a release due on the same edge.
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state   <= S_WAIT;
         timer   <= '0;
         idx     <= '0;
         rst_no  <= '0;
         ready_o <= 1'b0;
      end else if (!lock_s) begin
         state   <= S_WAIT;
         timer   <= '0;
         idx     <= '0;
         rst_no  <= '0;
         ready_o <= 1'b0;
      end else begin
         case (state)
            S_WAIT: begin
               state <= S_STABLE;
               timer <= TW'(1);
            end
            S_STABLE:
               if (timer == TW'(LOCK_CYCLES)) begin
                  rst_no[0] <= 1'b1;
                  idx       <= IW'(1);
                  timer     <= '0;
                  state     <= (NUM_STAGES == 1) ? S_RUN : S_RELEASE;
                  ready_o   <= (NUM_STAGES == 1);
               end else timer <= timer + 1'b1;
            S_RELEASE:
               if (timer == TW'(STAGE_CYCLES - 1)) begin
                  rst_no[idx] <= 1'b1;
                  idx         <= idx + 1'b1;
                  timer       <= '0;
                  if (idx == IW'(NUM_STAGES - 1)) begin
                     ready_o <= 1'b1;
                     state   <= S_RUN;
                  end
               end else timer <= timer + 1'b1;
            S_RUN: ;
            default: state <= S_WAIT;
         endcase
      end
`ifdef LOCK_LOSS_CNT_EN
   logic [CNT_W-1:0] cnt;
   // Only losses after the first release count; drops while still qualifying lock do not.
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) cnt <= '0;
      else if (!lock_s && (state == S_RELEASE || state == S_RUN) && cnt != '1) cnt <= cnt + 1'b1;
   assign lock_loss_cnt_o = cnt;
`endif
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed and randomized checks of three sequencer configurations
module tb_pll_reset_sequencer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [2:0] lk = 3'b000;
   logic [3:0] rn_a, rn_c;
   logic [0:0] rn_b;
   logic       rd_a, rd_b, rd_c;
`ifdef LOCK_LOSS_CNT_EN
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;
   logic [2:0] cnt_c;
`endif
   int tests = 0;
   int fails = 0;
   // reference model: per-instance parameters and abstract state
   int n_p[3] = '{4, 1, 4};
   int l_p[3] = '{1024, 1, 5};
   int s_p[3] = '{16, 16, 3};
   int cmax[3] = '{255, 3, 7};
   bit [1:0] sq[3];
   int run[3];
   int cnt[3];
   always #5 clk = ~clk;
   pll_reset_sequencer u_a (
      .clk_i(clk), .rst_ni(rst_n), .pll_locked_i(lk[0]), .rst_no(rn_a), .ready_o(rd_a)
`ifdef LOCK_LOSS_CNT_EN
      , .lock_loss_cnt_o(cnt_a)
`endif
   );
   pll_reset_sequencer #(.NUM_STAGES(1), .LOCK_CYCLES(1), .CNT_W(2)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .pll_locked_i(lk[1]), .rst_no(rn_b), .ready_o(rd_b)
`ifdef LOCK_LOSS_CNT_EN
      , .lock_loss_cnt_o(cnt_b)
`endif
   );
   pll_reset_sequencer #(.NUM_STAGES(4), .LOCK_CYCLES(5), .STAGE_CYCLES(3), .CNT_W(3)) u_c (
      .clk_i(clk), .rst_ni(rst_n), .pll_locked_i(lk[2]), .rst_no(rn_c), .ready_o(rd_c)
`ifdef LOCK_LOSS_CNT_EN
      , .lock_loss_cnt_o(cnt_c)
`endif
   );
   // stage k is released once synced lock has been seen high for LOCK+1+k*STAGE consecutive edges
   function automatic int nrel(input int d);
      int m = 0;
      if (run[d] > l_p[d]) m = 1 + (run[d] - l_p[d] - 1) / s_p[d];
      return (m > n_p[d]) ? n_p[d] : m;
   endfunction
   function automatic logic [31:0] exp_rn(input int d);
      return (32'd1 << nrel(d)) - 32'd1;
   endfunction
   function automatic logic [31:0] exp_rd(input int d);
      return {31'd0, nrel(d) == n_p[d]};
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic check_all();
      chk("a_rst_no", {28'd0, rn_a}, exp_rn(0));
      chk("a_ready", {31'd0, rd_a}, exp_rd(0));
      chk("b_rst_no", {31'd0, rn_b}, exp_rn(1));
      chk("b_ready", {31'd0, rd_b}, exp_rd(1));
      chk("c_rst_no", {28'd0, rn_c}, exp_rn(2));
      chk("c_ready", {31'd0, rd_c}, exp_rd(2));
`ifdef LOCK_LOSS_CNT_EN
      chk("a_cnt", {24'd0, cnt_a}, cnt[0]);
      chk("b_cnt", {30'd0, cnt_b}, cnt[1]);
      chk("c_cnt", {29'd0, cnt_c}, cnt[2]);
`endif
   endtask
   task automatic model_clear();
      for (int d = 0; d < 3; d++) begin
         sq[d] = 2'b00;
         run[d] = 0;
         cnt[d] = 0;
      end
   endtask
   task automatic step();
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
         if (!rst_n) begin
            sq[d] = 2'b00;
            run[d] = 0;
            cnt[d] = 0;
         end else begin
            if (sq[d][1]) run[d] = (run[d] < 1000000) ? run[d] + 1 : run[d];
            else begin
               if (nrel(d) > 0 && cnt[d] < cmax[d]) cnt[d]++;
               run[d] = 0;
            end
            sq[d] = {sq[d][0], lk[d]};
         end
      end
      #1 check_all();
   endtask
   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask
   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      model_clear();
      check_all();
   endtask
   initial begin
      model_clear();
      #1 async_reset();
      // reset held with lock high: outputs stay cleared
      lk = 3'b111;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t1_rst_no", {28'd0, rn_a}, 32'd0);
         chk("t1_ready", {31'd0, rd_a}, 32'd0);
      end
      lk = 3'b000;
      rst_n = 1'b1;
      steps(5);
      // clean bring-up on the default instance
      lk[0] = 1'b1;
      steps(1026);
      chk("t2_pre", {28'd0, rn_a}, 32'h0);
      step();
      chk("t2_s0", {28'd0, rn_a}, 32'h1);
      steps(15);
      chk("t2_s0_hold", {28'd0, rn_a}, 32'h1);
      step();
      chk("t2_s1", {28'd0, rn_a}, 32'h3);
      steps(16);
      chk("t2_s2", {28'd0, rn_a}, 32'h7);
      steps(15);
      chk("t2_rdy_pre", {31'd0, rd_a}, 32'h0);
      step();
      chk("t2_s3", {28'd0, rn_a}, 32'hf);
      chk("t2_rdy", {31'd0, rd_a}, 32'h1);
      // async reset while running clears everything immediately
      async_reset();
      chk("ar_rst_no", {28'd0, rn_a}, 32'h0);
      lk[0] = 1'b0;
      steps(3);
      rst_n = 1'b1;
      steps(3);
      // unstable lock: 500 high, 3 low, then the count restarts
      lk[0] = 1'b1;
      steps(500);
      lk[0] = 1'b0;
      steps(3);
      lk[0] = 1'b1;
      steps(1026);
      chk("t3_pre", {28'd0, rn_a}, 32'h0);
      step();
      chk("t3_s0", {28'd0, rn_a}, 32'h1);
      steps(48);
      chk("t3_rdy", {31'd0, rd_a}, 32'h1);
      // loss in RUN
      lk[0] = 1'b0;
      steps(2);
      chk("t4_hold", {28'd0, rn_a}, 32'hf);
      step();
      chk("t4_rst_no", {28'd0, rn_a}, 32'h0);
      chk("t4_ready", {31'd0, rd_a}, 32'h0);
`ifdef LOCK_LOSS_CNT_EN
      chk("t4_cnt", {24'd0, cnt_a}, 32'd1);
`endif
      // loss mid-release, then full re-sequence
      lk[0] = 1'b1;
      steps(1043);
      chk("t5_mid", {28'd0, rn_a}, 32'h3);
      lk[0] = 1'b0;
      steps(3);
      chk("t5_drop", {28'd0, rn_a}, 32'h0);
`ifdef LOCK_LOSS_CNT_EN
      chk("t5_cnt", {24'd0, cnt_a}, 32'd2);
`endif
      lk[0] = 1'b1;
      steps(1074);
      chk("t5_relock_pre", {31'd0, rd_a}, 32'h0);
      step();
      chk("t5_relock", {28'd0, rn_a}, 32'hf);
      // single-stage instance: rst_no and ready rise together, counter saturates
      for (int i = 0; i < 5; i++) begin
         lk[1] = 1'b1;
         steps(3);
         chk("t6_pre", {31'd0, rn_b}, 32'h0);
         step();
         chk("t6_rst_no", {31'd0, rn_b}, 32'h1);
         chk("t6_ready", {31'd0, rd_b}, 32'h1);
         steps(2);
         lk[1] = 1'b0;
         steps(4);
      end
`ifdef LOCK_LOSS_CNT_EN
      chk("t6_cnt_sat", {30'd0, cnt_b}, 32'd3);
`endif
      // randomized lock activity against the reference model
      for (int seg = 0; seg < 1500; seg++) begin
         if ($urandom_range(0, 49) == 0) begin
            async_reset();
            steps($urandom_range(0, 3));
            rst_n = 1'b1;
         end
         lk[2] = ($urandom_range(0, 3) != 0);
         lk[1] = ($urandom_range(0, 1) != 0);
         if ($urandom_range(0, 9) == 0) lk[0] = ~lk[0];
         steps($urandom_range(1, 30));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
